cs_detector_multi: RTL and testbench



---
 rtl/cs_detector_multi.sv | 237 +++++++++++++++++++++++
 tb/tb_cs_detector_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_detector_multi.sv
// cs_detector_multi: per-channel carrier-sense detector.
// Each channel computes |I|+|Q|, averages it over a 2^LOG_WIN sliding window,
// and runs a hysteresis/hold-off FSM that drives an enable-gated busy flag.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   set_stb/addr/data settings bus (enable mask, thr_high, thr_low, holdoff)
//   i_data, q_data   packed signed I/Q samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   strobe, run      sample valid (shared) and RX running
//   avg_out          packed per-channel window averages (SAMPLE_W+1 bits each)
//   avg_valid        one-cycle pulse when avg_out updates
//   carrier_present  per-channel busy flag gated by the enable mask
//   present_any      OR of carrier_present
module cs_detector_multi #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned LOG_WIN   = 4,
    parameter int unsigned BASE_ADDR = 66
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set_stb,
    input  logic [7:0]                      set_addr,
    input  logic [31:0]                     set_data,
    input  logic [NUM_CH*SAMPLE_W-1:0]      i_data,
    input  logic [NUM_CH*SAMPLE_W-1:0]      q_data,
    input  logic                            strobe,
    input  logic                            run,
    output logic [NUM_CH*(SAMPLE_W+1)-1:0]  avg_out,
    output logic                            avg_valid,
    output logic [NUM_CH-1:0]               carrier_present,
    output logic                            present_any
);

    localparam int unsigned MAG_W = SAMPLE_W + 1;
    localparam int unsigned SUM_W = MAG_W + LOG_WIN;
    localparam int unsigned WIN   = 1 << LOG_WIN;

    typedef enum logic [1:0] {WARMUP, CLEAR, BUSY, HOLD} state_t;

    // Sign-extend then negate negatives; the extra bit keeps |-2^(W-1)| exact.
    function automatic logic [MAG_W-1:0] abs_ext(input logic [SAMPLE_W-1:0] x);
        logic [MAG_W-1:0] ext;
        ext = {x[SAMPLE_W-1], x};
        return x[SAMPLE_W-1] ? (~ext) + MAG_W'(1) : ext;
    endfunction

    // ---------------- settings registers ----------------
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] en_d;
    logic [31:0]       thr_hi_q;
    logic [31:0]       thr_lo_q;
    logic [31:0]       thr_lo_eff;
    logic [15:0]       holdoff_q;
    logic              wr_en;
    logic              wr_hi;
    logic              wr_lo;
    logic              wr_hold;

    assign wr_en   = set_stb && (set_addr == 8'(BASE_ADDR));
    assign wr_hi   = set_stb && (set_addr == 8'(BASE_ADDR + 1));
    assign wr_lo   = set_stb && (set_addr == 8'(BASE_ADDR + 2));
    assign wr_hold = set_stb && (set_addr == 8'(BASE_ADDR + 3));

    // Next mask value, so a mask write reaches carrier_present one cycle later.
    assign en_d       = wr_en ? set_data[NUM_CH-1:0] : en_q;
    assign thr_lo_eff = (thr_lo_q < thr_hi_q) ? thr_lo_q : thr_hi_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q      <= '1;
            thr_hi_q  <= 32'd100;
            thr_lo_q  <= 32'd80;
            holdoff_q <= 16'd16;
        end else begin
            en_q <= en_d;
            if (wr_hi)   thr_hi_q  <= set_data;
            if (wr_lo)   thr_lo_q  <= set_data;
            if (wr_hold) holdoff_q <= set_data[15:0];
        end
    end

    // ---------------- stage 1: magnitude ----------------
    logic [MAG_W-1:0] mag_d [NUM_CH];
    logic [MAG_W-1:0] mag_q [NUM_CH];
    logic             mag_vld;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            mag_d[k] = abs_ext(i_data[k*SAMPLE_W +: SAMPLE_W])
                     + abs_ext(q_data[k*SAMPLE_W +: SAMPLE_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_vld <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) mag_q[k] <= '0;
        end else if (!run) begin
            mag_vld <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) mag_q[k] <= '0;
        end else begin
            mag_vld <= strobe;
            if (strobe) begin
                for (int unsigned k = 0; k < NUM_CH; k++) mag_q[k] <= mag_d[k];
            end
        end
    end

    // ---------------- stage 2: window sum and average ----------------
    logic [MAG_W-1:0]   win_q [NUM_CH][WIN];
    logic [SUM_W-1:0]   sum_q [NUM_CH];
    logic [SUM_W-1:0]   sum_d [NUM_CH];
    logic [LOG_WIN-1:0] wp_q;

    // Add the incoming magnitude, drop the one it overwrites.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            sum_d[k] = sum_q[k] + SUM_W'(mag_q[k]) - SUM_W'(win_q[k][wp_q]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                sum_q[k] <= '0;
                for (int unsigned j = 0; j < WIN; j++) win_q[k][j] <= '0;
            end
        end else if (!run) begin
            wp_q      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                sum_q[k] <= '0;
                for (int unsigned j = 0; j < WIN; j++) win_q[k][j] <= '0;
            end
        end else begin
            avg_valid <= mag_vld;
            if (mag_vld) begin
                wp_q <= wp_q + LOG_WIN'(1);
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    win_q[k][wp_q]             <= mag_q[k];
                    sum_q[k]                   <= sum_d[k];
                    avg_out[k*MAG_W +: MAG_W]  <= MAG_W'(sum_d[k] >> LOG_WIN);
                end
            end
        end
    end

    // ---------------- stage 3: hysteresis FSM ----------------
    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [15:0]        hold_q  [NUM_CH];
    logic [15:0]        hold_d  [NUM_CH];
    logic [LOG_WIN-1:0] warm_q  [NUM_CH];
    logic [LOG_WIN-1:0] warm_d  [NUM_CH];
    logic [31:0]        avg_w   [NUM_CH];
    logic [NUM_CH-1:0]  raw_d;

    always_comb begin
        raw_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            hold_d[k]  = hold_q[k];
            warm_d[k]  = warm_q[k];
            avg_w[k]   = 32'(avg_out[k*MAG_W +: MAG_W]);
            if (avg_valid) begin
                unique case (state_q[k])
                    WARMUP: begin
                        warm_d[k] = warm_q[k] + LOG_WIN'(1);
                        // The sample that fills the window is judged as in CLEAR.
                        if (warm_q[k] == LOG_WIN'(WIN - 1)) begin
                            state_d[k] = (avg_w[k] >= thr_hi_q) ? BUSY : CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (avg_w[k] >= thr_hi_q) state_d[k] = BUSY;
                    end
                    BUSY: begin
                        if (avg_w[k] < thr_lo_eff) begin
                            if (holdoff_q != 16'd0) begin
                                state_d[k] = HOLD;
                                hold_d[k]  = holdoff_q;
                            end else begin
                                state_d[k] = CLEAR;
                            end
                        end
                    end
                    HOLD: begin
                        // Re-trigger wins over hold expiry.
                        if (avg_w[k] >= thr_hi_q) begin
                            state_d[k] = BUSY;
                        end else if (hold_q[k] == 16'd1) begin
                            state_d[k] = CLEAR;
                        end else begin
                            hold_d[k] = hold_q[k] - 16'd1;
                        end
                    end
                    default: state_d[k] = WARMUP;
                endcase
            end
            raw_d[k] = (state_d[k] == BUSY) || (state_d[k] == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carrier_present <= '0;
            present_any     <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                state_q[k] <= WARMUP;
                hold_q[k]  <= '0;
                warm_q[k]  <= '0;
            end
        end else if (!run) begin
            carrier_present <= '0;
            present_any     <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                state_q[k] <= WARMUP;
                hold_q[k]  <= '0;
                warm_q[k]  <= '0;
            end
        end else begin
            carrier_present <= raw_d & en_d;
            present_any     <= |(raw_d & en_d);
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_d[k];
                hold_q[k]  <= hold_d[k];
                warm_q[k]  <= warm_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cs_detector_multi.sv
// Directed bench for cs_detector_multi (2 channels, 16-bit samples, 16-deep window).
module tb_cs_detector_multi;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned MAG_W    = SAMPLE_W + 1;
    localparam int unsigned BASE     = 66;

    logic                            clk;
    logic                            rst;
    logic                            set_stb;
    logic [7:0]                      set_addr;
    logic [31:0]                     set_data;
    logic [NUM_CH*SAMPLE_W-1:0]      i_data;
    logic [NUM_CH*SAMPLE_W-1:0]      q_data;
    logic                            strobe;
    logic                            run;
    logic [NUM_CH*MAG_W-1:0]         avg_out;
    logic                            avg_valid;
    logic [NUM_CH-1:0]               carrier_present;
    logic                            present_any;

    int n_assert = 0;
    int n_fail   = 0;
    int av_cnt   = 0;

    cs_detector_multi #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .LOG_WIN(4), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_data(i_data), .q_data(q_data), .strobe(strobe), .run(run),
        .avg_out(avg_out), .avg_valid(avg_valid),
        .carrier_present(carrier_present), .present_any(present_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (avg_valid) av_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i0, input int q0, input int i1, input int q1);
        i_data = {16'(i1), 16'(i0)};
        q_data = {16'(q1), 16'(q0)};
    endtask

    // n back-to-back strobes, then wait until the last sample's flag is visible.
    task automatic fill(input int n, input int i0, input int q0, input int i1, input int q1);
        drive(i0, q0, i1, q1);
        strobe = 1'b1;
        repeat (n) @(negedge clk);
        strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input int addr, input int data);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = 32'(data);
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    function automatic logic [63:0] avg0();
        return 64'(avg_out[MAG_W-1:0]);
    endfunction

    function automatic logic [63:0] avg1();
        return 64'(avg_out[2*MAG_W-1:MAG_W]);
    endfunction

    initial begin
        rst = 1'b0; run = 1'b0; strobe = 1'b0; set_stb = 1'b0;
        set_addr = '0; set_data = '0; i_data = '0; q_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_avg_out", 64'(avg_out), 64'd0);
        chk("rst_avg_valid", 64'(avg_valid), 64'd0);
        chk("rst_cp", 64'(carrier_present), 64'd0);
        chk("rst_any", 64'(present_any), 64'd0);
        rst = 1'b1; run = 1'b1;
        @(negedge clk);

        // Warmup: 16 back-to-back samples of mag 100.
        drive(60, 40, 60, 40);
        strobe = 1'b1;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            chk("warmup_cp", 64'(carrier_present), 64'd0);
        end
        strobe = 1'b0;
        @(negedge clk);
        chk("w16_avg_valid", 64'(avg_valid), 64'd1);
        chk("w16_avg0", avg0(), 64'd100);
        chk("w16_avg1", avg1(), 64'd100);
        chk("w16_cp_cycle2", 64'(carrier_present), 64'd0);
        @(negedge clk);
        chk("w16_cp_cycle3", 64'(carrier_present), 64'd3);
        chk("w16_any", 64'(present_any), 64'd1);
        chk("w16_pulses", 64'(av_cnt), 64'd16);

        // Hysteresis: mag 90 keeps BUSY; zeros drop into HOLD (holdoff 4).
        wr(BASE + 3, 4);
        fill(16, 50, 40, 50, 40);
        chk("hyst90_avg", avg0(), 64'd90);
        chk("hyst90_cp", 64'(carrier_present), 64'd3);
        fill(1, 0, 0, 0, 0);
        chk("z1_avg", avg0(), 64'd84);
        chk("z1_cp", 64'(carrier_present), 64'd3);
        fill(1, 0, 0, 0, 0);
        chk("z2_avg_hold", avg0(), 64'd78);
        chk("z2_cp", 64'(carrier_present), 64'd3);
        for (int s = 0; s < 3; s++) begin
            fill(1, 0, 0, 0, 0);
            chk("hold_cp", 64'(carrier_present), 64'd3);
        end
        fill(1, 0, 0, 0, 0);
        chk("hold_end_avg", avg0(), 64'd56);
        chk("hold_end_cp", 64'(carrier_present), 64'd0);
        chk("hold_end_any", 64'(present_any), 64'd0);

        // Re-trigger from HOLD on the sample where the counter would expire.
        fill(16, 60, 40, 60, 40);
        chk("rt_busy_cp", 64'(carrier_present), 64'd3);
        fill(4, 0, 0, 0, 0);
        chk("rt_hold_avg", avg0(), 64'd75);
        for (int s = 0; s < 4; s++) begin
            fill(1, 100, 100, 100, 100);
            chk("rt_cp", 64'(carrier_present), 64'd3);
        end
        chk("rt_avg", avg0(), 64'd100);
        fill(7, 0, 0, 0, 0);
        chk("reload_avg", avg0(), 64'd56);
        chk("reload_cp", 64'(carrier_present), 64'd3);
        fill(1, 0, 0, 0, 0);
        chk("reload_clear_cp", 64'(carrier_present), 64'd0);

        // Extreme samples: |-32768|+|-32768| = 65536.
        fill(16, -32768, -32768, -32768, -32768);
        chk("ext_avg0", avg0(), 64'd65536);
        chk("ext_avg1", avg1(), 64'd65536);
        chk("ext_cp", 64'(carrier_present), 64'd3);

        // thr_low above thr_high behaves as thr_high; holdoff 0 clears at once.
        wr(BASE + 2, 500);
        wr(BASE + 3, 0);
        fill(16, 100, 100, 100, 100);
        for (int s = 0; s < 2; s++) begin
            fill(1, 100, 100, 100, 100);
            chk("lo_eff_cp", 64'(carrier_present), 64'd3);
        end
        chk("lo_eff_avg", avg0(), 64'd200);
        fill(8, 0, 0, 0, 0);
        chk("lo_eff_edge_avg", avg0(), 64'd100);
        chk("lo_eff_edge_cp", 64'(carrier_present), 64'd3);
        fill(1, 0, 0, 0, 0);
        chk("h0_avg", avg0(), 64'd87);
        chk("h0_cp", 64'(carrier_present), 64'd0);

        // Enable mask gates outputs only.
        wr(BASE + 0, 1);
        fill(16, 0, 0, 100, 100);
        chk("mask_avg0", avg0(), 64'd0);
        chk("mask_avg1", avg1(), 64'd200);
        chk("mask_cp", 64'(carrier_present), 64'd0);
        chk("mask_any", 64'(present_any), 64'd0);
        wr(BASE + 0, 3);
        chk("unmask_cp", 64'(carrier_present), 64'd2);
        chk("unmask_any", 64'(present_any), 64'd1);

        // Abort: run low clears everything; strobes while low are ignored.
        run = 1'b0;
        @(negedge clk);
        chk("abort_cp", 64'(carrier_present), 64'd0);
        chk("abort_any", 64'(present_any), 64'd0);
        chk("abort_avg", 64'(avg_out), 64'd0);
        chk("abort_valid", 64'(avg_valid), 64'd0);
        fill(1, -32768, -32768, -32768, -32768);
        chk("abort_ignored_avg", 64'(avg_out), 64'd0);
        run = 1'b1;
        @(negedge clk);
        fill(15, 100, 100, 100, 100);
        chk("rewarm_avg", avg0(), 64'd187);
        chk("rewarm_cp", 64'(carrier_present), 64'd0);
        fill(1, 100, 100, 100, 100);
        chk("rewarm16_avg", avg1(), 64'd200);
        chk("rewarm16_cp", 64'(carrier_present), 64'd3);

        // Asynchronous reset mid-stream.
        strobe = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(avg_valid), 64'd0);
        chk("arst_avg", 64'(avg_out), 64'd0);
        chk("arst_cp", 64'(carrier_present), 64'd0);
        chk("arst_any", 64'(present_any), 64'd0);
        chk("arst_mask", 64'(dut.en_q), 64'd3);
        chk("arst_thr_hi", 64'(dut.thr_hi_q), 64'd100);
        chk("arst_thr_lo", 64'(dut.thr_lo_q), 64'd80);
        chk("arst_holdoff", 64'(dut.holdoff_q), 64'd16);
        strobe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_cp", 64'(carrier_present), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
